// File: rtl/apb_bcd_timer_scan.sv
// APB3 BCD up/down timer with reload, terminal-count interrupt and a
// multiplexed seven-segment scan driver; one clock, tick-enable prescaler.
module apb_bcd_timer_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIGITS  = 6,
    parameter int PRESCALE_RST = 24999
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   PSEL,
    input  logic [11:2]            PADDR,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [7:0]             seg,
    output logic [SCAN_DIGITS-1:0] dig,
    output logic                   irq
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int IW = (SCAN_DIGITS > 1) ? $clog2(SCAN_DIGITS) : 1;

    function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_digits(input logic [CW-1:0] v, input logic [3:0] d);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] != d) r = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    logic [4:0]    ctrl_q, ctrl_d;
    logic [15:0]   prescale_q, prescale_d;
    logic [15:0]   pcnt_q, pcnt_d;
    logic [CW-1:0] load_q, load_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] show_q, show_d;
    logic          term_q, term_d;
    logic [IW-1:0] idx_q, idx_d;

    logic wr, wr_ctrl, wr_cmd, wr_pre, wr_load, wr_stat;
    logic cmd_clr, cmd_ld, cmd_snap, tick, step, terminal;
    logic unused_bits;

    assign wr       = PSEL & PENABLE & PWRITE;
    assign wr_ctrl  = wr && (PADDR[4:2] == 3'd0);
    assign wr_cmd   = wr && (PADDR[4:2] == 3'd1);
    assign wr_pre   = wr && (PADDR[4:2] == 3'd2);
    assign wr_load  = wr && (PADDR[4:2] == 3'd3);
    assign wr_stat  = wr && (PADDR[4:2] == 3'd6);
    assign cmd_clr  = wr_cmd & PWDATA[0];
    assign cmd_ld   = wr_cmd & PWDATA[1];
    assign cmd_snap = wr_cmd & PWDATA[2];

    assign tick     = (pcnt_q == prescale_q);
    assign step     = tick & ctrl_q[0];
    assign terminal = ctrl_q[1] ? all_digits(count_q, 4'd0) : all_digits(count_q, 4'd9);

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign irq         = term_q & ctrl_q[3];
    assign unused_bits = ^{PADDR[11:5], PWDATA};

    always_comb begin
        ctrl_d     = wr_ctrl ? PWDATA[4:0] : ctrl_q;
        prescale_d = wr_pre ? PWDATA[15:0] : prescale_q;
        load_d     = wr_load ? sanitise(PWDATA[CW-1:0]) : load_q;
        pcnt_d     = (wr_pre || tick) ? 16'd0 : pcnt_q + 16'd1;
        idx_d      = idx_q;
        if (tick) idx_d = (idx_q == IW'(SCAN_DIGITS - 1)) ? '0 : idx_q + 1'b1;

        // Clear beats load beats a count step; terminal steps wrap or reload.
        count_d = count_q;
        if (cmd_clr)     count_d = '0;
        else if (cmd_ld) count_d = load_q;
        else if (step) begin
            if (terminal)
                count_d = ctrl_q[2] ? load_q : (ctrl_q[1] ? {NUM_DIGITS{4'h9}} : '0);
            else
                count_d = ctrl_q[1] ? bcd_dec(count_q) : bcd_inc(count_q);
        end

        term_d = term_q;
        if (step && terminal && !cmd_clr && !cmd_ld) term_d = 1'b1;
        else if (wr_stat && PWDATA[0])                term_d = 1'b0;

        show_d = (cmd_snap || ctrl_q[4]) ? count_q : show_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q     <= '0;
            prescale_q <= 16'(PRESCALE_RST);
            pcnt_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            show_q     <= '0;
            term_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            load_q     <= load_d;
            count_q    <= count_d;
            show_q     <= show_d;
            term_q     <= term_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (PADDR[4:2])
                3'd0:    PRDATA = {27'd0, ctrl_q};
                3'd2:    PRDATA = {16'd0, prescale_q};
                3'd3:    PRDATA = 32'(load_q);
                3'd4:    PRDATA = 32'(count_q);
                3'd5:    PRDATA = 32'(show_q);
                3'd6:    PRDATA = {31'd0, term_q};
                default: PRDATA = '0;
            endcase
        end
    end

    // Positions beyond the counter width are blanked.
    always_comb begin
        logic [3:0] digit;
        logic       shown;
        digit = '0;
        shown = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit = show_q[4*i +: 4];
                shown = 1'b1;
            end
        end
        seg = shown ? seg_code(digit) : 8'h00;
        for (int j = 0; j < SCAN_DIGITS; j++)
            dig[j] = (idx_q != IW'(j));
    end
endmodule

// File: tb/tb_apb_bcd_timer_scan.sv
// Scoreboard bench for apb_bcd_timer_scan: stimulus pushes expected reads and
// pin states into queues, a negedge monitor pops and compares them.
module tb_apb_bcd_timer_scan;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic [11:2] PADDR = '0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  seg;
    logic [5:0]  dig;
    logic        irq;

    apb_bcd_timer_scan #(.NUM_DIGITS(4), .SCAN_DIGITS(6), .PRESCALE_RST(24999)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .seg(seg), .dig(dig), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { string nm; logic [31:0] v; } rd_t;
    typedef struct { string nm; logic [5:0] d; logic [7:0] s; logic i; } pin_t;
    rd_t  rd_q[$];
    pin_t pin_q[$];
    logic pin_chk = 1'b0;
    int   errors = 0;
    int   checks = 0;

    localparam logic [2:0] A_CTRL = 3'd0, A_CMD = 3'd1, A_PRE = 3'd2, A_LOAD = 3'd3,
                           A_CNT = 3'd4, A_SHOW = 3'd5, A_STAT = 3'd6, A_RSV = 3'd7;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: read data in every read access phase, pins when flagged.
    always @(negedge PCLK) begin
        rd_t  r;
        pin_t p;
        if (PSEL && PENABLE && !PWRITE) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_underflow: got read with no expectation");
            end else begin
                r = rd_q.pop_front();
                chk(r.nm, PRDATA, r.v);
                chk({r.nm, "_pready"}, {31'd0, PREADY}, 32'd1);
                chk({r.nm, "_pslverr"}, {31'd0, PSLVERR}, 32'd0);
            end
        end
        if (pin_chk) begin
            if (pin_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pin_underflow: got pin check with no expectation");
            end else begin
                p = pin_q.pop_front();
                chk({p.nm, "_dig"}, {26'd0, dig}, {26'd0, p.d});
                chk({p.nm, "_seg"}, {24'd0, seg}, {24'd0, p.s});
                chk({p.nm, "_irq"}, {31'd0, irq}, {31'd0, p.i});
            end
        end
    end

    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = {7'd0, a}; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
        rd_t r;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = {7'd0, a}; PENABLE = 1'b0;
        r.nm = nm; r.v = exp;
        rd_q.push_back(r);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pin_check(input string nm, input int idx, input logic [7:0] s, input logic i);
        pin_t p;
        p.nm = nm; p.d = ~(6'd1 << idx); p.s = s; p.i = i;
        pin_q.push_back(p);
        pin_chk = 1'b1;
        @(negedge PCLK); #1;
        pin_chk = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    // PRESCALE=1 then freeze: exactly one tick lands between the two writes.
    task automatic one_tick();
        apb_write(A_PRE, 32'd1);
        apb_write(A_PRE, 32'h0000_FFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] seg_f [6] = '{8'h3F, 8'h06, 8'h3F, 8'h3F, 8'h00, 8'h00};

    initial begin
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Reset state
        pin_check("rst", 0, 8'h3F, 1'b0);
        apb_read(A_CTRL, 32'd0, "rst_ctrl");
        apb_read(A_CMD,  32'd0, "rst_cmd");
        apb_read(A_PRE,  32'd24999, "rst_pre");
        apb_read(A_LOAD, 32'd0, "rst_load");
        apb_read(A_CNT,  32'd0, "rst_count");
        apb_read(A_SHOW, 32'd0, "rst_show");
        apb_read(A_STAT, 32'd0, "rst_stat");
        apb_read(A_RSV,  32'd0, "rst_rsv");

        // Ten ticks at PRESCALE=2 counting up, then snapshot
        apply_reset();
        apb_write(A_CTRL, 32'h1);
        apb_write(A_PRE, 32'd2);
        repeat (27) @(posedge PCLK);
        apb_write(A_CTRL, 32'h0);
        apb_write(A_CMD, 32'h4);
        apb_read(A_CNT,  32'h0010, "up10_count");
        apb_read(A_SHOW, 32'h0010, "up10_show");

        // Up terminal 9999 -> 0000 with interrupt, then W1C
        apply_reset();
        apb_write(A_LOAD, 32'h9998);
        apb_write(A_CMD, 32'h2);
        apb_write(A_CTRL, 32'h9);
        one_tick();
        apb_read(A_CNT, 32'h9999, "upterm_c1");
        apb_read(A_STAT, 32'd0, "upterm_s1");
        one_tick();
        apb_read(A_CNT, 32'h0000, "upterm_c2");
        apb_read(A_STAT, 32'd1, "upterm_s2");
        pin_check("upterm_irq", 2, 8'h3F, 1'b1);
        apb_write(A_STAT, 32'h1);
        apb_read(A_STAT, 32'd0, "w1c_stat");
        pin_check("w1c_irq", 2, 8'h3F, 1'b0);

        // Down with reload: 0002,0001,0000,0002; IRQ_EN off
        apply_reset();
        apb_write(A_LOAD, 32'h0002);
        apb_write(A_CMD, 32'h2);
        apb_write(A_CTRL, 32'h7);
        one_tick();
        apb_read(A_CNT, 32'h0001, "dn_c1");
        one_tick();
        apb_read(A_CNT, 32'h0000, "dn_c2");
        apb_read(A_STAT, 32'd0, "dn_s2");
        one_tick();
        apb_read(A_CNT, 32'h0002, "dn_c3");
        apb_read(A_STAT, 32'd1, "dn_s3");
        pin_check("dn_noirq", 3, 8'h3F, 1'b0);

        // LOAD sanitising, CMD priority, snapshot of pre-update value
        apply_reset();
        apb_write(A_LOAD, 32'h00AF);
        apb_read(A_LOAD, 32'h0099, "load_sanit");
        apb_write(A_CMD, 32'h2);
        apb_read(A_CNT, 32'h0099, "cmd_load");
        apb_write(A_CMD, 32'h7);
        apb_read(A_CNT, 32'h0000, "cmd_clr_ld");
        apb_read(A_SHOW, 32'h0099, "snap_pre");
        apb_read(A_CMD, 32'd0, "cmd_rd0");
        apb_write(A_CTRL, 32'h3);
        apb_read(A_CTRL, 32'h3, "ctrl_rb");
        one_tick();
        apb_read(A_CNT, 32'h9999, "dn_wrap9");
        apb_read(A_STAT, 32'd1, "dn_wrap_term");

        // Scan every cycle with SHOW=0010
        apply_reset();
        apb_write(A_LOAD, 32'h0010);
        apb_write(A_CMD, 32'h2);
        apb_write(A_CMD, 32'h4);
        apb_write(A_PRE, 32'd0);
        for (int k = 0; k < 7; k++) begin
            pin_check($sformatf("scan%0d", k), k % 6, seg_f[k % 6], 1'b0);
            @(posedge PCLK); #1;
        end

        // Asynchronous reset mid-cycle
        #2 PRESETn = 1'b0;
        pin_check("async_rst", 0, 8'h3F, 1'b0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        apb_read(A_PRE, 32'd24999, "async_pre");
        apb_read(A_SHOW, 32'd0, "async_show");

        repeat (3) @(posedge PCLK);
        if (rd_q.size() != 0 || pin_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL queue_drain: got %0d reads %0d pins pending expected 0",
                     rd_q.size(), pin_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
